mmio_axil_bridge: RTL

Parametrised bridge between the core's single-outstanding MMIO request port and N AXI4-Lite master channels, one per peripheral (UART buffer, timers, future devices). It replaces the fixed single-UART AXI channel wired at the top level. Port selection comes from address bits. Per-transaction timeout and error reporting keep a stuck or absent peripheral from hanging the core.

---
 rtl/mmio_axil_bridge_if.sv | 45 ++++
 rtl/mmio_axil_bridge.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_axil_bridge_if.sv
// AXI4-Lite bundle for N_PORTS peripheral channels driven by mmio_axil_bridge.
// Port i occupies [32*i +: 32] of the address/data buses, [3*i +: 3] of the
// prot buses, [4*i +: 4] of wstrb, [2*i +: 2] of the resp buses and bit i of
// every valid/ready vector.
//   master : bridge side (drives addresses, data, valids, rready/bready)
//   slave  : peripheral side (drives readies, read data, responses)
interface mmio_axil_bridge_if #(
  parameter int unsigned N_PORTS = 2
) ();
  logic [N_PORTS*32-1:0] m_araddr;
  logic [N_PORTS*3-1:0]  m_arprot;
  logic [N_PORTS-1:0]    m_arvalid;
  logic [N_PORTS-1:0]    m_arready;
  logic [N_PORTS*32-1:0] m_rdata;
  logic [N_PORTS*2-1:0]  m_rresp;
  logic [N_PORTS-1:0]    m_rvalid;
  logic [N_PORTS-1:0]    m_rready;
  logic [N_PORTS*32-1:0] m_awaddr;
  logic [N_PORTS*3-1:0]  m_awprot;
  logic [N_PORTS-1:0]    m_awvalid;
  logic [N_PORTS-1:0]    m_awready;
  logic [N_PORTS*32-1:0] m_wdata;
  logic [N_PORTS*4-1:0]  m_wstrb;
  logic [N_PORTS-1:0]    m_wvalid;
  logic [N_PORTS-1:0]    m_wready;
  logic [N_PORTS*2-1:0]  m_bresp;
  logic [N_PORTS-1:0]    m_bvalid;
  logic [N_PORTS-1:0]    m_bready;

  modport master (
    output m_araddr, m_arprot, m_arvalid, input m_arready,
    input  m_rdata, m_rresp, m_rvalid, output m_rready,
    output m_awaddr, m_awprot, m_awvalid, input m_awready,
    output m_wdata, m_wstrb, m_wvalid, input m_wready,
    input  m_bresp, m_bvalid, output m_bready
  );

  modport slave (
    input  m_araddr, m_arprot, m_arvalid, output m_arready,
    output m_rdata, m_rresp, m_rvalid, input m_rready,
    input  m_awaddr, m_awprot, m_awvalid, output m_awready,
    input  m_wdata, m_wstrb, m_wvalid, output m_wready,
    output m_bresp, m_bvalid, input m_bready
  );
endinterface

// File: rtl/mmio_axil_bridge.sv
// Bridge from the core's single-outstanding MMIO request port to N_PORTS
// AXI4-Lite master channels. The channel is picked by
// req_addr[SEL_LSB +: SEL_W]; select values >= N_PORTS answer with an error.
// Every AXI handshake wait is bounded by TIMEOUT cycles.
// Ports:
//   clk, rstn            clock, synchronous active-low reset
//   req_valid/req_ready  request handshake (ready only while idle)
//   req_we, req_addr, req_wdata, req_wstrb   request payload
//   resp_valid           one-cycle response pulse
//   resp_rdata, resp_err read data (0 on writes/errors), error flag
//   axi                  AXI4-Lite master bundle, one channel per port
module mmio_axil_bridge #(
  parameter int unsigned N_PORTS = 2,
  parameter int unsigned SEL_LSB = 16,
  parameter int unsigned SEL_W   = 3,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  mmio_axil_bridge_if.master axi
);

  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  typedef enum logic [2:0] {IDLE, RADDR, RDATA, WRITE, WRESP, RESP} state_t;

  state_t             state;
  logic [31:0]        addr_q;
  logic [31:0]        wdata_q;
  logic [3:0]         wstrb_q;
  logic [N_PORTS-1:0] sel_oh;
  logic [N_PORTS-1:0] arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q;
  logic [CNT_W-1:0]   cnt;

  logic [SEL_W-1:0]   req_sel;
  logic [N_PORTS-1:0] req_oh;
  logic               req_unmapped;
  logic [31:0]        rdata_mux;
  logic [1:0]         rresp_mux, bresp_mux;
  logic               arready_hit, rvalid_hit, aw_hs, w_hs, bvalid_hit;
  logic               aw_pend, w_pend, tmo, abort_now;

  // Buses carry the latched request on every port; only the selected port
  // ever sees a valid or ready, so the others are don't-care.
  assign axi.m_araddr  = {N_PORTS{addr_q}};
  assign axi.m_awaddr  = {N_PORTS{addr_q}};
  assign axi.m_wdata   = {N_PORTS{wdata_q}};
  assign axi.m_wstrb   = {N_PORTS{wstrb_q}};
  assign axi.m_arprot  = '0;
  assign axi.m_awprot  = '0;
  assign axi.m_arvalid = arvalid_q;
  assign axi.m_rready  = rready_q;
  assign axi.m_awvalid = awvalid_q;
  assign axi.m_wvalid  = wvalid_q;
  assign axi.m_bready  = bready_q;

  always_comb begin
    req_sel = req_addr[SEL_LSB +: SEL_W];
    req_oh  = '0;
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      if (32'(req_sel) == i) req_oh[i] = 1'b1;
    end
  end

  assign req_unmapped = (32'(req_sel) >= N_PORTS);

  always_comb begin
    rdata_mux = '0;
    rresp_mux = '0;
    bresp_mux = '0;
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      if (sel_oh[i]) begin
        rdata_mux = rdata_mux | axi.m_rdata[32*i +: 32];
        rresp_mux = rresp_mux | axi.m_rresp[2*i +: 2];
        bresp_mux = bresp_mux | axi.m_bresp[2*i +: 2];
      end
    end
  end

  // Handshakes only count on the channel currently being driven.
  assign arready_hit = |(arvalid_q & axi.m_arready);
  assign rvalid_hit  = |(rready_q  & axi.m_rvalid);
  assign aw_hs       = |(awvalid_q & axi.m_awready);
  assign w_hs        = |(wvalid_q  & axi.m_wready);
  assign bvalid_hit  = |(bready_q  & axi.m_bvalid);
  assign aw_pend     = (|awvalid_q) && !aw_hs;
  assign w_pend      = (|wvalid_q)  && !w_hs;

  // cnt counts completed wait cycles; the TIMEOUT-th wait without progress aborts.
  assign tmo = (cnt == CNT_W'(TIMEOUT - 1));

  always_comb begin
    abort_now = 1'b0;
    if (tmo) begin
      case (state)
        RADDR:   abort_now = !arready_hit;
        RDATA:   abort_now = !rvalid_hit;
        WRITE:   abort_now = !aw_hs && !w_hs;
        WRESP:   abort_now = !bvalid_hit;
        default: abort_now = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      sel_oh     <= '0;
      arvalid_q  <= '0;
      rready_q   <= '0;
      awvalid_q  <= '0;
      wvalid_q   <= '0;
      bready_q   <= '0;
      cnt        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            wstrb_q   <= req_wstrb;
            sel_oh    <= req_oh;
            cnt       <= '0;
            req_ready <= 1'b0;
            if (req_unmapped) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else if (req_we) begin
              state     <= WRITE;
              awvalid_q <= req_oh;
              wvalid_q  <= req_oh;
            end else begin
              state     <= RADDR;
              arvalid_q <= req_oh;
            end
          end
        end
        RADDR: begin
          if (arready_hit) begin
            arvalid_q <= '0;
            rready_q  <= sel_oh;
            cnt       <= '0;
            state     <= RDATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RDATA: begin
          if (rvalid_hit) begin
            rready_q   <= '0;
            resp_err   <= |rresp_mux;
            resp_rdata <= (rresp_mux == 2'b00) ? rdata_mux : '0;
            resp_valid <= 1'b1;
            state      <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WRITE: begin
          // AW and W retire independently; each handshake restarts the wait.
          if (aw_hs) awvalid_q <= '0;
          if (w_hs)  wvalid_q  <= '0;
          if (!aw_pend && !w_pend) begin
            bready_q <= sel_oh;
            cnt      <= '0;
            state    <= WRESP;
          end else if (aw_hs || w_hs) begin
            cnt <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WRESP: begin
          if (bvalid_hit) begin
            bready_q   <= '0;
            resp_err   <= |bresp_mux;
            resp_rdata <= '0;
            resp_valid <= 1'b1;
            state      <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
          req_ready  <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Timeout overrides whatever the waiting state would have done.
      if (abort_now) begin
        arvalid_q  <= '0;
        rready_q   <= '0;
        awvalid_q  <= '0;
        wvalid_q   <= '0;
        bready_q   <= '0;
        resp_valid <= 1'b1;
        resp_err   <= 1'b1;
        resp_rdata <= '0;
        state      <= RESP;
      end
    end
  end

endmodule
